rob_commit: RTL and testbench

- 8-entry circular reorder buffer for the 2-way out-of-order core. Sits directly upstream of the 16x16 register file.
- Allocates up to two entries per cycle at dispatch, in program order.
- Accepts up to two out-of-order completions per cycle from the execution units.
- Retires at most one entry per cycle, in order, driving the register file's write port (addr / indata / ioch).

---
 rtl/rob_commit.sv | 139 +++++++++++++
 tb/tb_rob_commit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// 8-entry circular reorder buffer: dual in-order allocate, dual out-of-order
// complete, single in-order retire onto the register file write port.
module rob_commit #(
    parameter int DEPTH = 8,
    parameter int TW    = 3,
    parameter int DW    = 16,
    parameter int RW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    alloc_valid,
    input  logic [1:0]    alloc_wen,
    input  logic [RW-1:0] alloc_rd0,
    input  logic [RW-1:0] alloc_rd1,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag0,
    output logic [TW-1:0] alloc_tag1,
    input  logic [1:0]    cmp_valid,
    input  logic [TW-1:0] cmp_tag0,
    input  logic [TW-1:0] cmp_tag1,
    input  logic [DW-1:0] cmp_data0,
    input  logic [DW-1:0] cmp_data1,
    output logic [RW-1:0] reg_addr,
    output logic [DW-1:0] reg_indata,
    output logic          reg_ioch,
    output logic [TW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] wen;
    logic [RW-1:0]    rd   [DEPTH];
    logic [DW-1:0]    data [DEPTH];
    logic [TW-1:0]    head;
    logic [TW-1:0]    tail;
    logic [TW-1:0]    tail_p1;

    logic             commit;
    logic             alloc0;
    logic             alloc1;
    logic [TW:0]      n_alloc;
    logic [TW:0]      count_next;
    logic [DEPTH-1:0] hit0;
    logic [DEPTH-1:0] hit1;

    // alloc_valid/alloc_ready: a request is taken only on an edge where
    // alloc_ready is high; while it is low, dispatch holds the request.
    always_comb begin
        alloc_ready = (count <= (TW+1)'(DEPTH - 2));
        tail_p1     = tail + TW'(1);
        alloc_tag0  = tail;
        alloc_tag1  = tail_p1;
        alloc0      = alloc_ready && alloc_valid[0];
        alloc1      = alloc_ready && (alloc_valid == 2'b11);
        n_alloc     = (TW+1)'(alloc0) + (TW+1)'(alloc1);
        commit      = busy[head] && done[head];
        count_next  = count + n_alloc - (TW+1)'(commit);
        empty       = (count == '0);
        full        = (count == (TW+1)'(DEPTH));
    end

    // Completions only land on entries that were busy before the edge.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit0[i] = cmp_valid[0] && (cmp_tag0 == TW'(i)) && busy[i];
            hit1[i] = cmp_valid[1] && (cmp_tag1 == TW'(i)) && busy[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            done       <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            reg_addr   <= '0;
            reg_indata <= '0;
            reg_ioch   <= 1'b0;
        end else if (flush) begin
            busy     <= '0;
            done     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            reg_ioch <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit0[i] || hit1[i]) done[i] <= 1'b1;
            end
            // Retire clear comes after completion so a late overwrite of the
            // head entry cannot resurrect it.
            if (commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + TW'(1);
            end
            if (alloc0) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
            end
            if (alloc1) begin
                busy[tail_p1] <= 1'b1;
                done[tail_p1] <= 1'b0;
            end
            tail     <= tail + n_alloc[TW-1:0];
            count    <= count_next;
            reg_ioch <= commit && wen[head];
            if (commit && wen[head]) begin
                reg_addr   <= rd[head];
                reg_indata <= data[head];
            end
        end
    end

    // Payload carries no reset; it is only meaningful while busy is set.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit1[i])      data[i] <= cmp_data1;
                else if (hit0[i]) data[i] <= cmp_data0;
            end
            if (alloc0) begin
                wen[tail] <= alloc_wen[0];
                rd[tail]  <= alloc_rd0;
            end
            if (alloc1) begin
                wen[tail_p1] <= alloc_wen[1];
                rd[tail_p1]  <= alloc_rd1;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: register-file writes are scoreboarded in
// program order and every status check goes through one check task.
module tb_rob_commit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  alloc_valid;
    logic [1:0]  alloc_wen;
    logic [3:0]  alloc_rd0;
    logic [3:0]  alloc_rd1;
    logic        alloc_ready;
    logic [2:0]  alloc_tag0;
    logic [2:0]  alloc_tag1;
    logic [1:0]  cmp_valid;
    logic [2:0]  cmp_tag0;
    logic [2:0]  cmp_tag1;
    logic [15:0] cmp_data0;
    logic [15:0] cmp_data1;
    logic [3:0]  reg_addr;
    logic [15:0] reg_indata;
    logic        reg_ioch;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;
    int          checks;
    int          failures;
    logic [15:0] dval [8];

    rob_commit #(.DEPTH(8), .TW(3), .DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_wen(alloc_wen),
        .alloc_rd0(alloc_rd0), .alloc_rd1(alloc_rd1),
        .alloc_ready(alloc_ready), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
        .cmp_valid(cmp_valid), .cmp_tag0(cmp_tag0), .cmp_tag1(cmp_tag1),
        .cmp_data0(cmp_data0), .cmp_data1(cmp_data1),
        .reg_addr(reg_addr), .reg_indata(reg_indata), .reg_ioch(reg_ioch),
        .count(count), .empty(empty), .full(full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every register write must match the oldest expected write
    always @(negedge clk) begin
        if (rst && reg_ioch) begin
            if (exp_q.size() == 0) begin
                check("unexp_write", 32'(reg_ioch), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(mon_exp[19:16]));
                check("wr_data", 32'(reg_indata), 32'(mon_exp[15:0]));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [1:0] v, input logic [1:0] w,
                            input logic [3:0] r0, input logic [3:0] r1);
        alloc_valid = v;
        alloc_wen   = w;
        alloc_rd0   = r0;
        alloc_rd1   = r1;
        step();
        alloc_valid = 2'b00;
        alloc_wen   = 2'b00;
    endtask

    task automatic do_cmp(input logic [1:0] v, input logic [2:0] t0, input logic [15:0] d0,
                          input logic [2:0] t1, input logic [15:0] d1);
        cmp_valid = v;
        cmp_tag0  = t0;
        cmp_data0 = d0;
        cmp_tag1  = t1;
        cmp_data1 = d1;
        step();
        cmp_valid = 2'b00;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || count != 4'd0) && n < 60) begin
            step();
            n++;
        end
        check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_cnt"}, 32'(count), 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        alloc_valid = 2'b00;
        alloc_wen   = 2'b00;
        alloc_rd0   = 4'd0;
        alloc_rd1   = 4'd0;
        cmp_valid   = 2'b00;
        cmp_tag0    = 3'd0;
        cmp_tag1    = 3'd0;
        cmp_data0   = 16'd0;
        cmp_data1   = 16'd0;

        // reset and idle
        step();
        step();
        rst = 1'b1;
        repeat (5) step();
        check("rst_ioch", 32'(reg_ioch), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_tag0", 32'(alloc_tag0), 32'd0);
        check("rst_tag1", 32'(alloc_tag1), 32'd1);

        // pair, completed youngest first, retires in order
        exp_q.push_back({4'd3, 16'h1234});
        exp_q.push_back({4'd5, 16'hBEEF});
        do_alloc(2'b11, 2'b11, 4'd3, 4'd5);
        check("pair_count", 32'(count), 32'd2);
        check("pair_tag0", 32'(alloc_tag0), 32'd2);
        do_cmp(2'b01, 3'd1, 16'hBEEF, 3'd0, 16'h0000);
        check("pair_hold", 32'(reg_ioch), 32'd0);
        do_cmp(2'b01, 3'd0, 16'h1234, 3'd0, 16'h0000);
        check("lat_pre", 32'(reg_ioch), 32'd0);
        step();
        check("lat_ioch", 32'(reg_ioch), 32'd1);
        check("lat_addr", 32'(reg_addr), 32'd3);
        wait_drain("pair");

        // fill to full with silent entries starting at tag 2
        for (int i = 0; i < 3; i++) do_alloc(2'b11, 2'b00, 4'(i), 4'(i + 1));
        check("fill6_count", 32'(count), 32'd6);
        check("fill6_ready", 32'(alloc_ready), 32'd1);
        do_alloc(2'b11, 2'b00, 4'd9, 4'd9);
        check("full_count", 32'(count), 32'd8);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(alloc_ready), 32'd0);
        check("full_tag0", 32'(alloc_tag0), 32'd2);
        do_alloc(2'b11, 2'b00, 4'd9, 4'd9);
        check("full_ign_count", 32'(count), 32'd8);
        check("full_ign_tag0", 32'(alloc_tag0), 32'd2);
        do_cmp(2'b01, 3'd2, 16'h1111, 3'd0, 16'h0000);
        step();
        check("cnt7_count", 32'(count), 32'd7);
        check("cnt7_ready", 32'(alloc_ready), 32'd0);
        check("cnt7_full", 32'(full), 32'd0);
        do_alloc(2'b01, 2'b00, 4'd9, 4'd9);
        check("cnt7_ign", 32'(count), 32'd7);
        do_cmp(2'b11, 3'd3, 16'h0003, 3'd4, 16'h0004);
        do_cmp(2'b11, 3'd5, 16'h0005, 3'd6, 16'h0006);
        do_cmp(2'b11, 3'd7, 16'h0007, 3'd0, 16'h0008);
        do_cmp(2'b01, 3'd1, 16'h0009, 3'd0, 16'h0000);
        wait_drain("fill");

        // silent retire, then a normal write (tags 2, 3)
        do_alloc(2'b01, 2'b00, 4'd7, 4'd0);
        check("silent_count", 32'(count), 32'd1);
        do_cmp(2'b01, 3'd2, 16'hAAAA, 3'd0, 16'h0000);
        step();
        check("silent_retire", 32'(count), 32'd0);
        check("silent_ioch", 32'(reg_ioch), 32'd0);
        exp_q.push_back({4'd9, 16'h5A5A});
        do_alloc(2'b01, 2'b01, 4'd9, 4'd0);
        do_cmp(2'b01, 3'd3, 16'h5A5A, 3'd0, 16'h0000);
        wait_drain("wen1");

        // ignored 10 request, wrap-around, out-of-order, dual-port same tag
        do_alloc(2'b10, 2'b11, 4'd1, 4'd1);
        check("v10_count", 32'(count), 32'd0);
        check("v10_tag0", 32'(alloc_tag0), 32'd4);
        for (int t = 0; t < 8; t++) dval[t] = 16'($urandom_range(0, 65535));
        dval[2] = 16'h0002;
        for (int k = 0; k < 7; k++) exp_q.push_back({4'((4 + k) % 8 + 8), dval[(4 + k) % 8]});
        do_alloc(2'b01, 2'b11, 4'd12, 4'd0);
        do_alloc(2'b11, 2'b11, 4'd13, 4'd14);
        check("wrap_tag0", 32'(alloc_tag0), 32'd7);
        check("wrap_tag1", 32'(alloc_tag1), 32'd0);
        do_alloc(2'b11, 2'b11, 4'd15, 4'd8);
        do_alloc(2'b11, 2'b11, 4'd9, 4'd10);
        check("wrap_count", 32'(count), 32'd7);
        do_cmp(2'b11, 3'd1, 16'hDEAD, 3'd0, dval[0]);
        do_cmp(2'b11, 3'd7, dval[7], 3'd6, dval[6]);
        do_cmp(2'b11, 3'd1, dval[1], 3'd5, dval[5]);
        do_cmp(2'b01, 3'd4, dval[4], 3'd0, 16'h0000);
        do_cmp(2'b11, 3'd2, 16'h0001, 3'd2, 16'h0002);
        wait_drain("wrap");

        // completion to a non-busy entry is dropped (tag 3)
        do_cmp(2'b01, 3'd3, 16'h7777, 3'd0, 16'h0000);
        exp_q.push_back({4'd2, 16'h3333});
        do_alloc(2'b01, 2'b01, 4'd2, 4'd0);
        repeat (3) step();
        check("nb_count", 32'(count), 32'd1);
        check("nb_ioch", 32'(reg_ioch), 32'd0);
        do_cmp(2'b01, 3'd3, 16'h3333, 3'd0, 16'h0000);
        wait_drain("nb");

        // flush with a done head entry that would otherwise retire
        do_alloc(2'b11, 2'b11, 4'd1, 4'd2);
        do_alloc(2'b01, 2'b01, 4'd3, 4'd0);
        do_cmp(2'b01, 3'd4, 16'h4444, 3'd0, 16'h0000);
        check("pre_flush", 32'(count), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_ioch", 32'(reg_ioch), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_tag0", 32'(alloc_tag0), 32'd0);
        repeat (3) step();
        check("flush_idle", 32'(count), 32'd0);

        // asynchronous reset while a write is on the port
        exp_q.push_back({4'd12, 16'hC0C0});
        do_alloc(2'b11, 2'b11, 4'd12, 4'd13);
        do_cmp(2'b11, 3'd0, 16'hC0C0, 3'd1, 16'hD0D0);
        step();
        check("rstmid_ioch", 32'(reg_ioch), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_drop", 32'(reg_ioch), 32'd0);
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        step();
        step();
        rst = 1'b1;
        repeat (3) step();
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_tag0", 32'(alloc_tag0), 32'd0);

        check("sb_final", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
